// File: rtl/dram_cmd_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : dram_cmd_pkg / dram_cmd_if
//  Description : Request record type and the FIFO-side / command-trace bundle
//                shared by the DRAM command scheduler and its environment.
//  Revision    : 1.0 - initial release
// ============================================================================

package dram_cmd_pkg;
    typedef struct packed {
        logic [63:0] CPU_clock_count;
        logic [1:0]  opcode;
        logic [32:0] address;
    } parser_out_struct;
endpackage

interface dram_cmd_if;
    import dram_cmd_pkg::*;

    parser_out_struct fifo_output;
    logic             empty;
    logic             exit_flag;
    logic             cmd_valid;
    logic [1:0]       cmd_type;
    logic [1:0]       cmd_bg;
    logic [1:0]       cmd_bank;
    logic [14:0]      cmd_row;
    logic [9:0]       cmd_col;
    logic [63:0]      cmd_time;
    logic             busy;
    logic             illegal_op;

    // Environment side: owns the FIFO head, observes pops and commands.
    modport master (
        output fifo_output, empty,
        input  exit_flag, cmd_valid, cmd_type, cmd_bg, cmd_bank,
               cmd_row, cmd_col, cmd_time, busy, illegal_op
    );

    // Scheduler side.
    modport slave (
        input  fifo_output, empty,
        output exit_flag, cmd_valid, cmd_type, cmd_bg, cmd_bank,
               cmd_row, cmd_col, cmd_time, busy, illegal_op
    );
endinterface

`default_nettype wire

// File: rtl/dram_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : dram_cmd_scheduler
//  Description : Pops one request at a time from the parser FIFO and issues a
//                closed-page ACT / RD|WR / PRE sequence, spaced by timing
//                counters that tick once per DRAM cycle (two CPU cycles).
//  Revision    : 1.0 - initial release
// ============================================================================

module dram_cmd_scheduler #(
    parameter int T_RCD   = 24,
    parameter int T_RAS   = 52,
    parameter int T_CL    = 24,
    parameter int T_CWL   = 20,
    parameter int T_BURST = 4,
    parameter int T_WR    = 20,
    parameter int T_RP    = 24
) (
    input  logic      CPU_clock,
    input  logic      rst,
    dram_cmd_if.slave bus
);
    localparam int             CW     = 8;
    localparam logic [CW-1:0] C_RCD  = CW'(T_RCD);
    localparam logic [CW-1:0] C_RAS  = CW'(T_RAS);
    localparam logic [CW-1:0] C_RP   = CW'(T_RP);
    localparam logic [CW-1:0] C_RDAT = CW'(T_CL + T_BURST);
    localparam logic [CW-1:0] C_WDAT = CW'(T_CWL + T_BURST + T_WR);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    localparam logic [1:0] CMD_ACT = 2'd0;
    localparam logic [1:0] CMD_RD  = 2'd1;
    localparam logic [1:0] CMD_WR  = 2'd2;
    localparam logic [1:0] CMD_PRE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACT  = 2'd1,
        S_RW   = 2'd2,
        S_PRE  = 2'd3
    } state_t;

    state_t        state_q;
    logic          phase_q;
    logic [63:0]   time_q;
    logic [CW-1:0] rp_q, rcd_q, ras_q, dat_q;
    logic [CW-1:0] rp_d, rcd_d, ras_d, dat_d;

    // Latched request coordinates
    logic [14:0]   row_q;
    logic [9:0]    col_q;
    logic [1:0]    bank_q, bg_q;
    logic          wr_q;

    // Registered command trace
    logic          cmd_valid_q;
    logic [1:0]    cmd_type_q, cmd_bg_q, cmd_bank_q;
    logic [14:0]   cmd_row_q;
    logic [9:0]    cmd_col_q;
    logic [63:0]   cmd_time_q;
    logic          illegal_q;

    logic          dram_edge_d;
    logic          pop_d;
    logic [14:0]   row_d;
    logic [9:0]    col_d;
    logic [1:0]    bank_d, bg_d;
    logic [14:0]   act_row_d;
    logic [1:0]    act_bank_d, act_bg_d;

    // Decisions are taken one edge ahead: the cycle being entered is a DRAM
    // edge when the current phase is 0, and the counters tick on that edge.
    always_comb begin
        dram_edge_d = ~phase_q;
        rp_d        = (dram_edge_d && rp_q  != '0) ? rp_q  - C_ONE : rp_q;
        rcd_d       = (dram_edge_d && rcd_q != '0) ? rcd_q - C_ONE : rcd_q;
        ras_d       = (dram_edge_d && ras_q != '0) ? ras_q - C_ONE : ras_q;
        dat_d       = (dram_edge_d && dat_q != '0) ? dat_q - C_ONE : dat_q;
        pop_d       = ~rst && (state_q == S_IDLE) && ~bus.empty;
        row_d       = bus.fifo_output.address[32:18];
        col_d       = {bus.fifo_output.address[17:10], bus.fifo_output.address[5:4]};
        bank_d      = bus.fifo_output.address[9:8];
        bg_d        = bus.fifo_output.address[7:6];
        // ACT straight out of IDLE uses the FIFO head; otherwise the latch.
        act_row_d   = (state_q == S_IDLE) ? row_d  : row_q;
        act_bank_d  = (state_q == S_IDLE) ? bank_d : bank_q;
        act_bg_d    = (state_q == S_IDLE) ? bg_d   : bg_q;
    end

    assign bus.exit_flag  = pop_d;
    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_type   = cmd_type_q;
    assign bus.cmd_bg     = cmd_bg_q;
    assign bus.cmd_bank   = cmd_bank_q;
    assign bus.cmd_row    = cmd_row_q;
    assign bus.cmd_col    = cmd_col_q;
    assign bus.cmd_time   = cmd_time_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.illegal_op = illegal_q;

    // Request sequencer: pop, ACT, RD/WR, PRE with registered command outputs.
    always_ff @(posedge CPU_clock) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            time_q      <= '0;
            rp_q        <= '0;
            rcd_q       <= '0;
            ras_q       <= '0;
            dat_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            bank_q      <= '0;
            bg_q        <= '0;
            wr_q        <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= '0;
            cmd_bg_q    <= '0;
            cmd_bank_q  <= '0;
            cmd_row_q   <= '0;
            cmd_col_q   <= '0;
            cmd_time_q  <= '0;
            illegal_q   <= 1'b0;
        end else begin
            phase_q     <= ~phase_q;
            time_q      <= time_q + 64'd1;
            rp_q        <= rp_d;
            rcd_q       <= rcd_d;
            ras_q       <= ras_d;
            dat_q       <= dat_d;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= '0;
            cmd_bg_q    <= '0;
            cmd_bank_q  <= '0;
            cmd_row_q   <= '0;
            cmd_col_q   <= '0;
            cmd_time_q  <= '0;
            illegal_q   <= 1'b0;

            case (state_q)
                S_IDLE, S_ACT: begin
                    if (state_q == S_IDLE && pop_d) begin
                        row_q  <= row_d;
                        col_q  <= col_d;
                        bank_q <= bank_d;
                        bg_q   <= bg_d;
                        wr_q   <= (bus.fifo_output.opcode == 2'd1);
                    end
                    if (state_q == S_IDLE && pop_d && bus.fifo_output.opcode == 2'd3) begin
                        illegal_q <= 1'b1;
                    end else if (state_q == S_ACT || pop_d) begin
                        // ACT is held until the DRAM edge where RP has expired.
                        if (dram_edge_d && rp_d == '0) begin
                            cmd_valid_q <= 1'b1;
                            cmd_type_q  <= CMD_ACT;
                            cmd_bg_q    <= act_bg_d;
                            cmd_bank_q  <= act_bank_d;
                            cmd_row_q   <= act_row_d;
                            cmd_time_q  <= time_q + 64'd1;
                            ras_q       <= C_RAS;
                            rcd_q       <= C_RCD;
                            state_q     <= S_RW;
                        end else begin
                            state_q     <= S_ACT;
                        end
                    end
                end
                S_RW: begin
                    if (dram_edge_d && rcd_d == '0) begin
                        cmd_valid_q <= 1'b1;
                        cmd_type_q  <= wr_q ? CMD_WR : CMD_RD;
                        cmd_bg_q    <= bg_q;
                        cmd_bank_q  <= bank_q;
                        cmd_col_q   <= col_q;
                        cmd_time_q  <= time_q + 64'd1;
                        dat_q       <= wr_q ? C_WDAT : C_RDAT;
                        state_q     <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (dram_edge_d && ras_d == '0 && dat_d == '0) begin
                        cmd_valid_q <= 1'b1;
                        cmd_type_q  <= CMD_PRE;
                        cmd_bg_q    <= bg_q;
                        cmd_bank_q  <= bank_q;
                        cmd_time_q  <= time_q + 64'd1;
                        rp_q        <= C_RP;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
